vector_processing_block: RTL
============================

Name: vector_processing_block

Overview:
- Parametrised successor to the fixed 16x32-bit processing block.
- Fetches 32-bit instructions one at a time from an external instruction memory over a PC-addressed read port, and executes them against an internal vector register file.
- Lane count, lane width, register count and PC width are parameters.
- Adds valid/ready handshakes on main-memory load and store, a SUB op, HALT, and illegal-opcode detection.

Parameters:
LANES, 16, number of vector lanes
LANE_W, 32, bits per lane; vector width = LANES*LANE_W
NREGS, 16, vector registers (2..256)
PC_W, 16, program counter / instruction address width

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
instr_addr  out  PC_W  instruction fetch address, equals pc
instr_data  in  32  instruction at instr_addr, combinational same-cycle read
load_addr  out  16  main-memory load address
load_ctrl  out  1  load request, held until accepted
load_valid  in  1  load_data valid, completes load
load_data  in  LANES*LANE_W  load return data
write_addr  out  16  main-memory store address
write_data  out  LANES*LANE_W  store data
write_ctrl  out  1  store request, held until accepted
write_ready  in  1  memory accepts store this cycle
halted  out  1  core stopped (HALT or illegal)
error  out  1  stopped due to illegal instruction
pc  out  PC_W  current program counter

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low; it is sampled on the rising clock edge while reset_n=0.
- Reset values: pc=0, state=EXEC, load_ctrl=0, write_ctrl=0, load_addr=0, write_addr=0, write_data=0, halted=0, error=0. Register file is not cleared.
- Reset mid-operation: an outstanding load/store is dropped on the same edge; ctrl is low the next cycle.
- Instruction format: [31:24] opcode, [23:16] rd/rs, [15:8] ra, [7:0] rb, [15:0] address for LOAD/STORE.
- Opcodes: 0x00 NOP, 0x01 ADD, 0x02 MUL, 0x03 SUB, 0x10 STORE, 0x20 LOAD, 0xFF HALT. Any other opcode is illegal.
- Any register index >= NREGS in a field the opcode uses is illegal.
- States: EXEC, LOAD_WAIT, STORE_WAIT, HALT.
- EXEC, NOP: pc+1. 1 cycle.
- EXEC, ADD/SUB/MUL: lane-wise on ra, rb. Result truncated to the low LANE_W bits, unsigned wrap. Written to rd at the edge; pc+1. 1 cycle. rd may equal ra/rb; the old values are read.
- EXEC, LOAD: at the edge, load_ctrl<=1, load_addr<=addr, go to LOAD_WAIT.
- LOAD_WAIT: on an edge with load_valid=1, rd<=load_data, load_ctrl<=0, pc+1, go to EXEC.
- LOAD minimum is 2 cycles. load_valid is ignored outside LOAD_WAIT.
- EXEC, STORE: at the edge, write_ctrl<=1, write_addr<=addr, write_data<=reg[rs], go to STORE_WAIT.
- STORE_WAIT: addr and data are held stable. On an edge with write_ready=1, write_ctrl<=0, pc+1, go to EXEC. Minimum 2 cycles.
- HALT opcode: halted<=1, go to HALT. pc is not incremented.
- Illegal instruction: halted<=1, error<=1, go to HALT. No register or memory side effect.
- HALT state: absorbing until reset. Outputs are frozen.
- pc wraps from 2^PC_W-1 to 0.
- load_ctrl and write_ctrl are never both high.
- Only one instruction is in flight, so there are no hazards.

Test Plan:
- Program LOAD r0<-m0, LOAD r1<-m1, LOAD r2<-m2, MUL r3=r0*r1, ADD r4=r3+r2, STORE m3<-r4, HALT. Memory lanes are 3, 5, 7; load_valid and write_ready are tied high. Required: load_ctrl high with load_addr 0/1/2 in cycles 1, 3, 5; write_ctrl high in cycle 9 with write_addr 3 and every lane 22; halted=1 from cycle 11.
- SUB 0-1 and MUL 0x10000*0x10000 -> all lanes 0xFFFFFFFF and 0x00000000 respectively.
- STORE with write_ready low for 3 cycles -> write_ctrl, addr and data held stable 4 cycles; pc advances only after the accept edge.
- LOAD with load_valid delayed 5 cycles, plus a spurious load_valid pulse during a preceding ADD -> register written only on the LOAD_WAIT accept edge; ADD result unaffected.
- Opcode 0x55 at pc=2, then separately rd=NREGS -> halted=1, error=1 next cycle; pc stays 2; no load_ctrl/write_ctrl ever asserted afterwards.
- reset_n low for 1 cycle during LOAD_WAIT -> load_ctrl=0 and pc=0 the following cycle; program re-executes from 0 correctly.

Source files
------------

// File: rtl/vector_processing_block.sv
// Vector processing block: fetches one 32-bit instruction per step and executes
// it lane-wise against a vector register file. Main-memory loads and stores
// use request/response handshakes. HALT and illegal instructions stop the core.
module vector_processing_block #(
  parameter int LANES  = 16,
  parameter int LANE_W = 32,
  parameter int NREGS  = 16,
  parameter int PC_W   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic [PC_W-1:0]         instr_addr,
  input  logic [31:0]             instr_data,
  output logic [15:0]             load_addr,
  output logic                    load_ctrl,
  input  logic                    load_valid,
  input  logic [LANES*LANE_W-1:0] load_data,
  output logic [15:0]             write_addr,
  output logic [LANES*LANE_W-1:0] write_data,
  output logic                    write_ctrl,
  input  logic                    write_ready,
  output logic                    halted,
  output logic                    error,
  output logic [PC_W-1:0]         pc
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int IDX_W = $clog2(NREGS);
  localparam logic [8:0] NREGS_LIM = 9'(NREGS);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_STORE = 8'h10;
  localparam logic [7:0] OP_LOAD  = 8'h20;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [1:0] {
    S_EXEC,
    S_LOAD_WAIT,
    S_STORE_WAIT,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               load_ctrl_q, load_ctrl_d;
  logic [15:0]        load_addr_q, load_addr_d;
  logic               write_ctrl_q, write_ctrl_d;
  logic [15:0]        write_addr_q, write_addr_d;
  logic [VEC_W-1:0]   write_data_q, write_data_d;
  logic               halted_q, halted_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   rd_q, rd_d;

  // Register file is deliberately not reset; only the write port is controlled.
  logic [VEC_W-1:0]   regfile_q [NREGS];
  logic               rf_we;
  logic [IDX_W-1:0]   rf_waddr;
  logic [VEC_W-1:0]   rf_wdata;

  logic [7:0]         opcode, f_rd, f_ra, f_rb;
  logic [15:0]        mem_addr;
  logic               rd_ok, ra_ok, rb_ok;
  logic [IDX_W-1:0]   rd_idx, ra_idx, rb_idx;
  logic [VEC_W-1:0]   op_a, op_b, op_s, alu_res;
  logic [PC_W-1:0]    pc_inc;
  logic               illegal;

  assign opcode   = instr_data[31:24];
  assign f_rd     = instr_data[23:16];
  assign f_ra     = instr_data[15:8];
  assign f_rb     = instr_data[7:0];
  assign mem_addr = instr_data[15:0];

  // Register fields are only legal when they name an existing register.
  assign rd_ok  = {1'b0, f_rd} < NREGS_LIM;
  assign ra_ok  = {1'b0, f_ra} < NREGS_LIM;
  assign rb_ok  = {1'b0, f_rb} < NREGS_LIM;
  assign rd_idx = f_rd[IDX_W-1:0];
  assign ra_idx = f_ra[IDX_W-1:0];
  assign rb_idx = f_rb[IDX_W-1:0];

  assign op_a   = regfile_q[ra_idx];
  assign op_b   = regfile_q[rb_idx];
  assign op_s   = regfile_q[rd_idx];
  assign pc_inc = pc_q + PC_STEP;

  // Lane-wise ALU; each lane result is truncated to LANE_W bits (unsigned wrap).
  always_comb begin
    alu_res = '0;
    for (int l = 0; l < LANES; l++) begin
      case (opcode)
        OP_ADD:  alu_res[l*LANE_W +: LANE_W] = op_a[l*LANE_W +: LANE_W] + op_b[l*LANE_W +: LANE_W];
        OP_SUB:  alu_res[l*LANE_W +: LANE_W] = op_a[l*LANE_W +: LANE_W] - op_b[l*LANE_W +: LANE_W];
        default: alu_res[l*LANE_W +: LANE_W] = op_a[l*LANE_W +: LANE_W] * op_b[l*LANE_W +: LANE_W];
      endcase
    end
  end

  // Next-state, handshake and register-write decisions for the single in-flight instruction.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load_ctrl_d  = load_ctrl_q;
    load_addr_d  = load_addr_q;
    write_ctrl_d = write_ctrl_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    halted_d     = halted_q;
    error_d      = error_q;
    rd_d         = rd_q;
    rf_we        = 1'b0;
    rf_waddr     = rd_idx;
    rf_wdata     = alu_res;
    illegal      = 1'b0;
    unique case (state_q)
      S_EXEC: begin
        case (opcode)
          OP_NOP: pc_d = pc_inc;
          OP_ADD, OP_SUB, OP_MUL: begin
            if (rd_ok && ra_ok && rb_ok) begin
              rf_we = 1'b1;
              pc_d  = pc_inc;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_LOAD: begin
            if (rd_ok) begin
              load_ctrl_d = 1'b1;
              load_addr_d = mem_addr;
              rd_d        = rd_idx;
              state_d     = S_LOAD_WAIT;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_STORE: begin
            if (rd_ok) begin
              write_ctrl_d = 1'b1;
              write_addr_d = mem_addr;
              write_data_d = op_s;
              state_d      = S_STORE_WAIT;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
          halted_d = 1'b1;
          error_d  = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_LOAD_WAIT: begin
        if (load_valid) begin
          rf_we       = 1'b1;
          rf_waddr    = rd_q;
          rf_wdata    = load_data;
          load_ctrl_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = S_EXEC;
        end
      end
      S_STORE_WAIT: begin
        if (write_ready) begin
          write_ctrl_d = 1'b0;
          pc_d         = pc_inc;
          state_d      = S_EXEC;
        end
      end
      S_HALT: begin
      end
    endcase
  end

  // Control state register with synchronous active-low reset; drops any pending request.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_EXEC;
      pc_q         <= '0;
      load_ctrl_q  <= 1'b0;
      load_addr_q  <= '0;
      write_ctrl_q <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      load_ctrl_q  <= load_ctrl_d;
      load_addr_q  <= load_addr_d;
      write_ctrl_q <= write_ctrl_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      halted_q     <= halted_d;
      error_q      <= error_d;
      rd_q         <= rd_d;
    end
  end

  // Register file write port; a reset edge suppresses any write in progress.
  always_ff @(posedge clock) begin
    if (reset_n && rf_we) begin
      regfile_q[rf_waddr] <= rf_wdata;
    end
  end

  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign load_ctrl  = load_ctrl_q;
  assign load_addr  = load_addr_q;
  assign write_ctrl = write_ctrl_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign halted     = halted_q;
  assign error      = error_q;

endmodule
